spi_cs_sequencer: RTL and testbench
===================================

# spi_cs_sequencer

Transaction-level front end for the SPI master datapath. Accepts framed command words on an AXI-Stream input (tlast marks the final word of one chip-select transaction), drives a single active-low chip select with programmable setup, hold and inter-transaction gap, and issues words one at a time to the SPI master's word interface. Returns each received word on an AXI-Stream output with tlast aligned to the command framing. Sits directly upstream of the SPI master, between it and the host/DMA stream.

## Interface
- AXIS_DATA_WIDTH, 8: word width; must equal the SPI master's data width.
- DELAY_WIDTH, 8: width of the cs setup/hold/gap counters.

- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  AXIS_DATA_WIDTH  command word.
- s_axis_tvalid / s_axis_tready  in / out  1  command handshake.
- s_axis_tlast  in  1  last word of transaction.
- m_axis_tdata  out  AXIS_DATA_WIDTH  received word.
- m_axis_tvalid / m_axis_tready  out / in  1  response handshake.
- m_axis_tlast  out  1  response word belongs to the command word that carried tlast.
- m_spi_tdata / m_spi_tvalid / m_spi_tready  out / out / in  AXIS_DATA_WIDTH / 1 / 1  word to SPI master.
- s_spi_tdata / s_spi_tvalid / s_spi_tready  in / in / out  AXIS_DATA_WIDTH / 1 / 1  word from SPI master.
- spi_bus_active  in  1  SPI master busy (sclk not yet back at idle polarity).
- cs_setup_cycles, cs_hold_cycles, cs_gap_cycles  in  DELAY_WIDTH each  delays in clk cycles; latched at transaction start.
- cs_n  out  1  chip select, active low.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SETUP, FETCH, ISSUE, RECV, HOLD, GAP.
- IDLE: s_axis_tready=0. On s_axis_tvalid: latch the three delay inputs, cs_n<=0, cnt<=cs_setup_cycles, go SETUP. The word is not consumed here.
- SETUP: cnt!=0 -> decrement; cnt==0 -> FETCH.
- FETCH: s_axis_tready=1. On handshake latch tdata into word_reg and tlast into last_reg; go ISSUE.
- ISSUE: m_spi_tvalid=1, m_spi_tdata=word_reg. On m_spi_tready -> RECV.
- RECV: s_spi_tready = !m_axis_tvalid || m_axis_tready. On s_spi handshake: m_axis_tdata<=s_spi_tdata, m_axis_tlast<=last_reg, m_axis_tvalid<=1. Then last_reg ? (cnt<=cs_hold_cycles, HOLD) : FETCH.
- HOLD: decrement cnt to 0. Leave only when cnt==0 and spi_bus_active==0: cs_n<=1, cnt<=cs_gap_cycles, go GAP.
- GAP: decrement; cnt==0 -> IDLE.
- m_axis output register: cleared on m_axis_tvalid && m_axis_tready unless reloaded in the same cycle. Reload takes priority.
- Delay value 0: the state lasts exactly one cycle. Value N: the state lasts N+1 cycles; HOLD lasts longer if spi_bus_active is still high.
- cs_n stays low across all words of one frame. It never toggles between words.

## Timing
- Reset values: cs_n=1, busy=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_spi_tvalid=0, s_spi_tready=0, state IDLE. All counters are 0.
- Reset mid-transaction: immediate. cs_n rises asynchronously, all valids drop, and in-flight words are lost.
- cs_n falls on the clk edge after s_axis_tvalid is seen in IDLE. The first m_spi_tvalid asserts no earlier than cs_setup_cycles+2 cycles later.
- m_axis_tvalid rises one cycle after the s_spi handshake.
- Exactly one word is outstanding to the SPI master at a time. s_spi_tready held low while the output register is full is the backpressure mechanism. The SPI master is never given a second word before its response is taken.
- s_axis_tready, m_spi_tvalid and s_spi_tready are decoded from state and registers only. There is no combinational path between the input and output handshakes.

## Structure
- spi_pkg: state enum typedef (spi_seq_state_t) and a DELAY_WIDTH default constant, shared with future SPI blocks.
- One sub-module, spi_cs_timer: a loadable DELAY_WIDTH down-counter with a zero flag, reused for setup, hold and gap.
- RTL is expected at about 150–250 lines.

## Test plan
- Single word 0xA5 with tlast, setup=2, hold=1, gap=3, loopback SPI model returning 0x5A:
  - cs_n low ≥4 cycles before m_spi_tvalid.
  - m_axis returns 0x5A with tlast=1.
  - cs_n high ≥2 cycles after the response and only once spi_bus_active=0.
  - next cs_n fall ≥4 cycles later.
- Frame 0x01,0x02,0x03 (tlast on 0x03): cs_n stays low throughout; responses arrive in order with tlast on the third word only.
- All delays 0, back-to-back single-word frames: each state lasts 1 cycle, and cs_n pulses high for exactly 2 cycles between frames.
- m_axis_tready held low for 20 cycles mid-frame: s_spi_tready=0 and no second m_spi_tvalid; after release, no word is lost or duplicated.
- spi_bus_active held high 10 cycles after the last response: cs_n remains low until it falls.
- rst_n asserted during ISSUE of word 2 of 3: cs_n=1 and all valids=0 immediately. After release, a new frame completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction blocks.
//   spi_seq_state_t : chip-select sequencer state encoding
//   SPI_DELAY_WIDTH : default width of cs setup/hold/gap delay counters
package spi_pkg;

   localparam int SPI_DELAY_WIDTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_FETCH = 3'd2,
      ST_ISSUE = 3'd3,
      ST_RECV  = 3'd4,
      ST_HOLD  = 3'd5,
      ST_GAP   = 3'd6
   } spi_seq_state_t;

endpackage

// File: rtl/spi_cs_timer.sv
// Loadable down-counter used for the cs setup, hold and gap intervals.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load       : load load_val (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one, saturating at zero
//   zero       : count is zero
module spi_cs_timer
   import spi_pkg::*;
#(
   parameter int DELAY_WIDTH = SPI_DELAY_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [DELAY_WIDTH-1:0] load_val,
   input  logic                   dec,
   output logic                   zero
);

   logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/spi_cs_sequencer.sv
// Transaction front end for the SPI master: frames command words under one
// active-low chip select with programmable setup/hold/gap, issues one word at
// a time to the SPI master and returns each received word on an AXIS output.
//   s_axis_*        : command words in, tlast closes the cs transaction
//   m_axis_*        : received words out, tlast follows the command framing
//   m_spi_*/s_spi_* : word interface to / from the SPI master
//   spi_bus_active  : SPI master still shifting; holds cs low in HOLD
//   cs_*_cycles     : delays in clk cycles, latched when a transaction starts
//   cs_n, busy      : chip select, sequencer not idle
//
// state | meaning
// IDLE  | cs high, waiting for a command word to start a transaction
// SETUP | cs low, counting setup delay
// FETCH | accepting the next command word
// ISSUE | offering the word to the SPI master
// RECV  | waiting for the SPI response, stalls while output register is full
// HOLD  | counting hold delay and waiting for the SPI bus to go idle
// GAP   | cs high, counting minimum gap before the next transaction
module spi_cs_sequencer
   import spi_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH = 8,
   parameter int DELAY_WIDTH     = SPI_DELAY_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic [AXIS_DATA_WIDTH-1:0] m_spi_tdata,
   output logic                       m_spi_tvalid,
   input  logic                       m_spi_tready,
   input  logic [AXIS_DATA_WIDTH-1:0] s_spi_tdata,
   input  logic                       s_spi_tvalid,
   output logic                       s_spi_tready,
   input  logic                       spi_bus_active,
   input  logic [DELAY_WIDTH-1:0]     cs_setup_cycles,
   input  logic [DELAY_WIDTH-1:0]     cs_hold_cycles,
   input  logic [DELAY_WIDTH-1:0]     cs_gap_cycles,
   output logic                       cs_n,
   output logic                       busy
);

   spi_seq_state_t             state_q, state_d;
   logic                       cs_n_q, cs_n_d;
   logic [AXIS_DATA_WIDTH-1:0] word_q, word_d;
   logic                       last_q, last_d;
   logic [DELAY_WIDTH-1:0]     hold_q, hold_d;
   logic [DELAY_WIDTH-1:0]     gap_q, gap_d;
   logic [AXIS_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                       rx_valid_q, rx_valid_d;
   logic                       rx_last_q, rx_last_d;

   logic                       tmr_load, tmr_dec, tmr_zero;
   logic [DELAY_WIDTH-1:0]     tmr_val;
   logic                       rx_ready;

   spi_cs_timer #(.DELAY_WIDTH(DELAY_WIDTH)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // The response register can take a new word when empty or draining this
   // cycle; this is the only backpressure towards the SPI master.
   assign rx_ready = (state_q == ST_RECV) && (!rx_valid_q || m_axis_tready);

   always_comb begin
      state_d    = state_q;
      cs_n_d     = cs_n_q;
      word_d     = word_q;
      last_d     = last_q;
      hold_d     = hold_q;
      gap_d      = gap_q;
      rx_data_d  = rx_data_q;
      rx_last_d  = rx_last_q;
      rx_valid_d = rx_valid_q && !m_axis_tready;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      tmr_dec    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (s_axis_tvalid) begin
               hold_d   = cs_hold_cycles;
               gap_d    = cs_gap_cycles;
               cs_n_d   = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = cs_setup_cycles;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_zero) state_d = ST_FETCH;
            else          tmr_dec = 1'b1;
         end
         ST_FETCH: begin
            if (s_axis_tvalid) begin
               word_d  = s_axis_tdata;
               last_d  = s_axis_tlast;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (m_spi_tready) state_d = ST_RECV;
         end
         ST_RECV: begin
            if (s_spi_tvalid && rx_ready) begin
               rx_data_d  = s_spi_tdata;
               rx_last_d  = last_q;
               rx_valid_d = 1'b1;
               if (last_q) begin
                  tmr_load = 1'b1;
                  tmr_val  = hold_q;
                  state_d  = ST_HOLD;
               end else begin
                  state_d  = ST_FETCH;
               end
            end
         end
         ST_HOLD: begin
            if (!tmr_zero) begin
               tmr_dec = 1'b1;
            end else if (!spi_bus_active) begin
               cs_n_d   = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = gap_q;
               state_d  = ST_GAP;
            end
         end
         ST_GAP: begin
            if (tmr_zero) state_d = ST_IDLE;
            else          tmr_dec = 1'b1;
         end
         default: begin
            cs_n_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cs_n_q     <= 1'b1;
         word_q     <= '0;
         last_q     <= 1'b0;
         hold_q     <= '0;
         gap_q      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cs_n_q     <= cs_n_d;
         word_q     <= word_d;
         last_q     <= last_d;
         hold_q     <= hold_d;
         gap_q      <= gap_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_last_q  <= rx_last_d;
      end
   end

   assign s_axis_tready = (state_q == ST_FETCH);
   assign m_spi_tvalid  = (state_q == ST_ISSUE);
   assign m_spi_tdata   = word_q;
   assign s_spi_tready  = rx_ready;
   assign m_axis_tdata  = rx_data_q;
   assign m_axis_tvalid = rx_valid_q;
   assign m_axis_tlast  = rx_last_q;
   assign cs_n          = cs_n_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Scoreboard bench for spi_cs_sequencer. The SPI master is modelled as a
// responder returning the bitwise inverse of each issued word; command words
// push their expected response, a monitor pops on every m_axis handshake and
// also checks cs timing against the frame's delays.
module tb_spi_cs_sequencer;

   localparam int DW = 8;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [DW-1:0] m_spi_tdata;
   logic          m_spi_tvalid;
   logic          m_spi_tready;
   logic [DW-1:0] s_spi_tdata;
   logic          s_spi_tvalid;
   logic          s_spi_tready;
   logic          spi_bus_active;
   logic [LW-1:0] cs_setup_cycles = '0;
   logic [LW-1:0] cs_hold_cycles = '0;
   logic [LW-1:0] cs_gap_cycles = '0;
   logic          cs_n;
   logic          busy;

   spi_cs_sequencer #(.AXIS_DATA_WIDTH(DW), .DELAY_WIDTH(LW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .s_axis_tlast    (s_axis_tlast),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .m_axis_tlast    (m_axis_tlast),
      .m_spi_tdata     (m_spi_tdata),
      .m_spi_tvalid    (m_spi_tvalid),
      .m_spi_tready    (m_spi_tready),
      .s_spi_tdata     (s_spi_tdata),
      .s_spi_tvalid    (s_spi_tvalid),
      .s_spi_tready    (s_spi_tready),
      .spi_bus_active  (spi_bus_active),
      .cs_setup_cycles (cs_setup_cycles),
      .cs_hold_cycles  (cs_hold_cycles),
      .cs_gap_cycles   (cs_gap_cycles),
      .cs_n            (cs_n),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int su;
      int ho;
      int ga;
      int len;
      int pres;
   } frame_t;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   frame_t        frame_q[$];
   logic [8:0]    exp_q[$];
   logic [DW-1:0] fdata[$];

   bit  abort = 1'b0;
   bit  hold_off = 1'b0;
   bit  drv_done = 1'b0;
   int  tail_force = -1;
   int  spi_lat_max = 3;
   int  rdy_pct = 100;
   int  stall_tok = 0;
   int  spi_hs_count = 0;

   always @(posedge clk) cyc = cyc + 1;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void chk_ge(input string name, input int act, input int minv);
      checks++;
      if (act < minv) begin
         errors++;
         $display("FAIL %s: got %0d expected >= %0d (cycle %0d)", name, act, minv, cyc);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- response-side ready, with stall requests ----------------
   initial begin
      int seen_tok;
      int stall_left;
      seen_tok = 0;
      stall_left = 0;
      m_axis_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (stall_tok != seen_tok) begin
            seen_tok = stall_tok;
            stall_left = 20;
         end
         if (stall_left > 0) begin
            m_axis_tready = 1'b0;
            stall_left--;
         end else begin
            m_axis_tready = ($urandom_range(99) < rdy_pct);
         end
      end
   end

   // ---------------- SPI master model: returns ~word ----------------
   initial begin
      logic [DW-1:0] w;
      int lat;
      int tl;
      m_spi_tready = 1'b0;
      s_spi_tvalid = 1'b0;
      s_spi_tdata = '0;
      spi_bus_active = 1'b0;
      forever begin
         tick();
         m_spi_tready = !hold_off && ($urandom_range(3) != 0);
         if (m_spi_tready && m_spi_tvalid) begin
            w = m_spi_tdata;
            tick();
            m_spi_tready = 1'b0;
            spi_bus_active = 1'b1;
            lat = $urandom_range(spi_lat_max);
            repeat (lat) tick();
            s_spi_tdata = ~w;
            s_spi_tvalid = 1'b1;
            while (!s_spi_tready && rst_n) tick();
            tick();
            s_spi_tvalid = 1'b0;
            tl = (tail_force >= 0) ? tail_force : $urandom_range(2);
            repeat (tl) tick();
            spi_bus_active = 1'b0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   frame_t cur;
   bit     have_frame = 1'b0;
   bit     have_rise = 1'b0;
   bit     seen_first = 1'b0;
   int     fall_cyc = 0;
   int     rise_cyc = 0;
   int     gap_prev = 0;
   int     last_hs_cyc = 0;
   int     outstanding = 0;
   int     words = 0;
   logic   prev_cs = 1'b1;
   logic   prev_bus = 1'b0;
   logic   prev_mspi = 1'b0;

   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst_n) begin
         have_frame = 1'b0;
         have_rise = 1'b0;
         outstanding = 0;
      end else begin
         if (prev_cs && !cs_n) begin
            if (frame_q.size() == 0) begin
               chk("frame_start_expected", 1, 0);
               have_frame = 1'b0;
            end else begin
               cur = frame_q.pop_front();
               have_frame = 1'b1;
               seen_first = 1'b0;
               words = 0;
               fall_cyc = cyc;
               if (have_rise) begin
                  int exp_fall;
                  exp_fall = rise_cyc + gap_prev + 2;
                  if (cur.pres + 1 > exp_fall) exp_fall = cur.pres + 1;
                  chk("cs_gap_fall_cycle", cyc, exp_fall);
               end
            end
         end
         if (!prev_cs && cs_n && have_frame) begin
            chk_ge("cs_hold_cycles", cyc - last_hs_cyc, cur.ho + 1);
            chk("cs_rise_bus_idle", prev_bus, 0);
            chk("frame_words_under_cs", words, cur.len);
            rise_cyc = cyc;
            gap_prev = cur.ga;
            have_rise = 1'b1;
            have_frame = 1'b0;
         end
         if (m_spi_tvalid && !prev_mspi) begin
            chk("issue_cs_low", cs_n, 0);
            chk("one_outstanding", outstanding, 0);
            if (have_frame && !seen_first) begin
               chk("setup_to_first_issue", cyc - fall_cyc, cur.su + 2);
               seen_first = 1'b1;
            end
         end
         if (m_spi_tvalid && m_spi_tready) begin
            outstanding++;
            spi_hs_count++;
            words++;
         end
         if (s_spi_tvalid && s_spi_tready) begin
            outstanding--;
            last_hs_cyc = cyc + 1;
         end
         if (m_axis_tvalid && !m_axis_tready) chk("backpressure_s_spi_tready", s_spi_tready, 0);
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_response", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_data", m_axis_tdata, e[8:1]);
               chk("resp_last", m_axis_tlast, e[0]);
            end
         end
      end
      prev_cs = cs_n;
      prev_bus = spi_bus_active;
      prev_mspi = m_spi_tvalid;
   end

   // ---------------- command driver ----------------
   task automatic send_word(input logic [DW-1:0] d, input logic l, input bit first,
                            input int su, input int ho, input int ga, input int len);
      int t;
      frame_t fr;
      t = 0;
      if (first) begin
         cs_setup_cycles = LW'(su);
         cs_hold_cycles = LW'(ho);
         cs_gap_cycles = LW'(ga);
         fr.su = su; fr.ho = ho; fr.ga = ga; fr.len = len; fr.pres = cyc;
         frame_q.push_back(fr);
      end
      s_axis_tdata = d;
      s_axis_tlast = l;
      s_axis_tvalid = 1'b1;
      while (!s_axis_tready && !abort && t < 1000) begin
         tick();
         t++;
      end
      if (abort || t >= 1000) begin
         if (!abort) begin
            chk("s_axis_accept_timeout", t, 0);
            abort = 1'b1;
         end
         s_axis_tvalid = 1'b0;
         return;
      end
      tick();
      exp_q.push_back({~d, l});
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      if (first) begin
         // Delays must have been latched at transaction start.
         cs_setup_cycles = LW'($urandom_range(255));
         cs_hold_cycles = LW'($urandom_range(255));
         cs_gap_cycles = LW'($urandom_range(255));
      end
   endtask

   task automatic send_frame(input int su, input int ho, input int ga);
      int n;
      n = fdata.size();
      for (int i = 0; i < n; i++) begin
         if (abort) break;
         send_word(fdata[i], (i == n - 1), (i == 0), su, ho, ga, n);
      end
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((busy || exp_q.size() != 0) && t < 3000) begin
         tick();
         t++;
      end
      if (t >= 3000) chk(name, t, 0);
   endtask

   initial begin
      int base;
      int t;
      int n;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_cs_n", cs_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_s_axis_tready", s_axis_tready, 0);
      chk("rst_m_axis_tvalid", m_axis_tvalid, 0);
      chk("rst_m_axis_tlast", m_axis_tlast, 0);
      chk("rst_m_axis_tdata", m_axis_tdata, 0);
      chk("rst_m_spi_tvalid", m_spi_tvalid, 0);
      chk("rst_s_spi_tready", s_spi_tready, 0);
      rst_n = 1'b1;
      tick();

      // Single word, setup=2 hold=1 gap=3: response 0x5A with tlast.
      fdata = {8'hA5};
      send_frame(2, 1, 3);

      // Three-word frame under one cs.
      fdata = {8'h01, 8'h02, 8'h03};
      send_frame(1, 2, 1);

      // All delays zero, back-to-back single-word frames.
      tail_force = 0;
      spi_lat_max = 0;
      for (int i = 0; i < 4; i++) begin
         fdata = {8'($urandom_range(255))};
         send_frame(0, 0, 0);
      end
      tail_force = -1;
      spi_lat_max = 3;

      // Output held off for 20 cycles mid-frame.
      fdata = {8'h10, 8'h20, 8'h30, 8'h40};
      drv_done = 1'b0;
      fork
         begin
            send_frame(1, 1, 1);
            drv_done = 1'b1;
         end
      join_none
      t = 0;
      while (!m_axis_tvalid && t < 500) begin tick(); t++; end
      if (t >= 500) chk("stall_wait_response_timeout", t, 0);
      stall_tok++;
      t = 0;
      while (!drv_done && t < 1000) begin tick(); t++; end
      if (t >= 1000) chk("stall_frame_timeout", t, 0);

      // SPI bus busy for 10 cycles after the response; cs must wait.
      tail_force = 10;
      fdata = {8'h77};
      send_frame(0, 0, 2);
      wait_idle("bus_active_drain_timeout");
      tail_force = -1;

      // Reset while word 2 of 3 is being issued.
      fdata = {8'hC1, 8'hC2, 8'hC3};
      base = spi_hs_count;
      drv_done = 1'b0;
      fork
         begin
            send_frame(1, 1, 1);
            drv_done = 1'b1;
         end
      join_none
      t = 0;
      while (spi_hs_count < base + 1 && t < 500) begin tick(); t++; end
      if (t >= 500) chk("reset_word1_timeout", t, 0);
      hold_off = 1'b1;
      t = 0;
      while (!m_spi_tvalid && t < 500) begin tick(); t++; end
      if (t >= 500) chk("reset_word2_issue_timeout", t, 0);
      repeat (2) tick();
      abort = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midrst_cs_n", cs_n, 1);
      chk("midrst_m_spi_tvalid", m_spi_tvalid, 0);
      chk("midrst_m_axis_tvalid", m_axis_tvalid, 0);
      chk("midrst_s_spi_tready", s_spi_tready, 0);
      chk("midrst_s_axis_tready", s_axis_tready, 0);
      chk("midrst_busy", busy, 0);
      t = 0;
      while (!drv_done && t < 50) begin tick(); t++; end
      if (t >= 50) chk("reset_driver_exit_timeout", t, 0);
      exp_q.delete();
      frame_q.delete();
      hold_off = 1'b0;
      abort = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      fdata = {8'h3C, 8'hC3};
      send_frame(2, 1, 2);

      // Randomized frames with random delays, latencies and output readiness.
      rdy_pct = 70;
      for (int f = 0; f < 20; f++) begin
         n = $urandom_range(4, 1);
         fdata.delete();
         for (int i = 0; i < n; i++) fdata.push_back(8'($urandom_range(255)));
         send_frame($urandom_range(4), $urandom_range(4), $urandom_range(4));
      end

      wait_idle("final_drain_timeout");
      repeat (5) tick();
      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_cs_n", cs_n, 1);
      chk("final_outstanding", outstanding, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
